// File: rtl/fp32_pkg.sv
// rtl/fp32_pkg.sv - fp32 field layout, special constants and unpacked-float type
package fp32_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [31:0] FP32_QNAN     = 32'h7FC00000;
  localparam logic [31:0] FP32_POS_ZERO = 32'h00000000;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] mant;
  } fp32_t;

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != '0);
  endfunction

endpackage

// File: rtl/fp32_add_comb.sv
// rtl/fp32_add_comb.sv - combinational fp32 adder, RNE, subnormals flushed to signed zero
module fp32_add_comb
  import fp32_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] sum_o
);

  fp32_t       ua, ub, big, sml;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [26:0] m_big, m_sml, m_shift, m_norm;
  logic [27:0] m_sum;
  logic [7:0]  d;
  logic        sticky, found, rnd_up;
  logic [4:0]  lz;
  logic [9:0]  e_res;
  logic [24:0] m_rnd;

  always_comb begin
    ua     = fp32_t'(a_i);
    ub     = fp32_t'(b_i);
    a_nan  = (ua.exp == 8'hFF) && (ua.mant != '0);
    b_nan  = (ub.exp == 8'hFF) && (ub.mant != '0);
    a_inf  = (ua.exp == 8'hFF) && (ua.mant == '0);
    b_inf  = (ub.exp == 8'hFF) && (ub.mant == '0);
    a_zero = (ua.exp == '0);
    b_zero = (ub.exp == '0);

    // Order by magnitude so the subtraction path never goes negative
    if ({ua.exp, ua.mant} >= {ub.exp, ub.mant}) begin
      big = ua;
      sml = ub;
    end else begin
      big = ub;
      sml = ua;
    end

    m_big   = {1'b1, big.mant, 3'b000};
    m_sml   = {1'b1, sml.mant, 3'b000};
    d       = big.exp - sml.exp;
    m_shift = '0;
    sticky  = 1'b0;
    if (d >= 8'd27) begin
      sticky = 1'b1;
    end else begin
      m_shift = m_sml >> d;
      sticky  = |(m_sml & ((27'd1 << d) - 27'd1));
    end
    m_shift[0] = m_shift[0] | sticky;

    if (big.sign == sml.sign) m_sum = {1'b0, m_big} + {1'b0, m_shift};
    else                      m_sum = {1'b0, m_big} - {1'b0, m_shift};

    e_res = {2'b00, big.exp};
    found = 1'b0;
    lz    = '0;
    if (m_sum[27]) begin
      m_norm = m_sum[27:1] | {26'd0, m_sum[0]};
      e_res  = e_res + 10'd1;
    end else begin
      for (int i = 26; i >= 0; i--) begin
        if (!found && m_sum[i]) begin
          found = 1'b1;
          lz    = 5'(26 - i);
        end
      end
      m_norm = m_sum[26:0] << lz;
      e_res  = e_res - {5'd0, lz};
    end

    // Guard is bit 2, round/sticky below, lsb is bit 3
    rnd_up = m_norm[2] && (m_norm[3] || m_norm[1] || m_norm[0]);
    m_rnd  = {1'b0, m_norm[26:3]} + {24'd0, rnd_up};
    if (m_rnd[24]) begin
      m_rnd = m_rnd >> 1;
      e_res = e_res + 10'd1;
    end

    if (a_nan || b_nan)              sum_o = FP32_QNAN;
    else if (a_inf && b_inf)         sum_o = (ua.sign == ub.sign) ? a_i : FP32_QNAN;
    else if (a_inf)                  sum_o = a_i;
    else if (b_inf)                  sum_o = b_i;
    else if (a_zero && b_zero)       sum_o = {ua.sign & ub.sign, 31'd0};
    else if (a_zero)                 sum_o = b_i;
    else if (b_zero)                 sum_o = a_i;
    else if (m_sum == '0)            sum_o = FP32_POS_ZERO;
    else if (e_res[9] || e_res == '0) sum_o = {big.sign, 31'd0};
    else if (e_res >= 10'd255)       sum_o = {big.sign, 8'hFF, 23'd0};
    else                             sum_o = {big.sign, e_res[7:0], m_rnd[22:0]};
  end

endmodule

// File: rtl/adder_n_input_pipeline_floating_point32.sv
// rtl/adder_n_input_pipeline_floating_point32.sv - serial fp32 accumulator summing groups of NUM_INPUTS samples
// Optional ReLU on the emitted sum is enabled by defining ADDER_N_RELU_OUT_EN.
module adder_n_input_pipeline_floating_point32
  import fp32_pkg::*;
#(
  parameter int NUM_INPUTS = 3,
  parameter int CNT_W      = $clog2(NUM_INPUTS + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic [31:0] i_data,
  input  logic        i_clear,
  output logic [31:0] o_data,
  output logic        o_valid,
  output logic        o_busy
);

  logic [31:0]      acc_q, acc_d, o_data_q, o_data_d;
  logic [31:0]      sum, result, out_val;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             o_valid_q, o_valid_d;
  logic             start, last;

  fp32_add_comb u_add (
    .a_i  (acc_q),
    .b_i  (i_data),
    .sum_o(sum)
  );

  // A clear with a sample restarts the group on that sample
  assign start  = i_clear || (cnt_q == '0);
  assign last   = start ? (NUM_INPUTS == 1) : (cnt_q == CNT_W'(NUM_INPUTS - 1));
  assign result = start ? i_data : sum;

`ifdef ADDER_N_RELU_OUT_EN
  assign out_val = is_nan(result) ? FP32_QNAN : (result[31] ? FP32_POS_ZERO : result);
`else
  assign out_val = result;
`endif

  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    o_data_d  = o_data_q;
    o_valid_d = 1'b0;
    if (i_clear) cnt_d = '0;
    if (i_valid) begin
      acc_d = result;
      if (last) begin
        cnt_d     = '0;
        o_data_d  = out_val;
        o_valid_d = 1'b1;
      end else begin
        cnt_d = start ? CNT_W'(1) : cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      o_data_q  <= FP32_POS_ZERO;
      o_valid_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      o_data_q  <= o_data_d;
      o_valid_q <= o_valid_d;
    end
  end

  assign o_data  = o_data_q;
  assign o_valid = o_valid_q;
  assign o_busy  = (cnt_q != '0);

endmodule

// File: doc/adder_n_input_pipeline_floating_point32.md
Name: adder_n_input_pipeline_floating_point32

Overview:
- Serial IEEE-754 single-precision accumulator that sums groups of NUM_INPUTS consecutive valid samples.
- Emits one fp32 sum per completed group.
- Generalises the fixed 3-input serial adder to any group size.
- Adds a group-abort input and an optional ReLU output stage.
- Sits after the multiply stage of a DQN neuron node: weight-products stream in and the neuron pre-activation streams out.

Parameters:
- NUM_INPUTS, 3, samples per group; legal range 1..1024.
- CNT_W, $clog2(NUM_INPUTS+1), width of the group counter; derived, do not override.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- i_valid  in  1  i_data carries a sample this cycle.
- i_data  in  32  fp32 sample.
- i_clear  in  1  discard the partial group.
- o_data  out  32  fp32 group sum; held between pulses.
- o_valid  out  1  one-cycle pulse when o_data is a new sum.
- o_busy  out  1  high while a partial group is held (count != 0).

Behaviour:
- Reset: rst sampled high on a clk edge sets acc=0, count=0, o_data=32'h00000000, o_valid=0, o_busy=0. A partial group is discarded. A sample presented in the reset cycle is ignored.
- Counter and accumulator, on i_valid && !i_clear:
  - count==0: acc <= i_data.
  - otherwise: acc <= fadd(acc, i_data).
  - count increments.
- Group completion: when count==NUM_INPUTS-1 and a sample is accepted:
  - o_data <= fadd(acc, i_data), or i_data alone when NUM_INPUTS==1.
  - o_valid <= 1 on the next edge.
  - count <= 0.
  - Latency is 1 cycle from the last sample to o_valid.
- Throughput: one sample per cycle with no stall. Back-to-back groups are supported; a new group's first sample may arrive in the cycle after the previous group's last sample.
- Gaps: i_valid low holds acc and count. Any gap length is allowed inside a group.
- i_clear:
  - Sets count <= 0; acc is don't-care.
  - If i_valid is also high, that sample starts a new group: acc <= i_data, count <= 1. For NUM_INPUTS==1 it completes immediately.
  - i_clear never produces o_valid.
- o_valid is low in every cycle except completion. o_data changes only on completion.
- fadd arithmetic:
  - Round-to-nearest-even.
  - Subnormal inputs and results flush to signed zero.
  - Overflow gives ±Inf.
  - Inf + finite gives Inf; +Inf + -Inf gives 32'h7FC00000.
  - Any NaN operand gives 32'h7FC00000.
  - Exact zero result is +0, except (-0)+(-0), which gives -0.
- Accumulation order is strictly sample order, left-fold: ((x0+x1)+x2)+...

Optional Feature:
- Macro: ADDER_N_RELU_OUT_EN.
- Defined: at completion, a sum with sign bit 1 (including -0, and excluding NaN) is replaced by 32'h00000000. NaN passes as 32'h7FC00000. Latency is unchanged.
- Undefined: the raw sum is output.

Decomposition:
- Shared package fp32_pkg:
  - Field widths/positions: EXP_W=8, MAN_W=23, BIAS=127.
  - Constants FP32_QNAN=32'h7FC00000 and FP32_POS_ZERO.
  - Unpacked-float typedef {sign, exp, mant}.
- Sub-module fp32_add_comb: purely combinational two-operand adder implementing the fadd rules above.
- The top level owns the counter, accumulator, clear and reset logic, and the optional ReLU.

Test Plan:
- NUM_INPUTS=3, reset high 2 cycles then low. Stream 40A00000, 40A00000, 40A00000, 40900000, 40200000, 41080000 back-to-back. Required: o_valid pulses exactly twice, with 41700000 (15.0) 1 cycle after sample 3 and 41780000 (15.5) 1 cycle after sample 6.
- Same stream with i_valid low for 3 cycles between samples 2 and 3, and for 1 cycle between samples 4 and 5. Required: same two sums, each 1 cycle after its last sample, and no extra pulses.
- Send 40A00000, 40A00000, then i_clear with i_valid and i_data=3F800000, then 40000000, 40400000. Required: a single sum 40C00000 (6.0).
- Reset mid-group: after 2 samples assert rst for 1 cycle, then send 3F800000 ×3. Required: o_data=00000000 and o_valid=0 during reset, then one sum 40400000.
- Special values: (7F800000, 3F800000, 3F800000) gives 7F800000. (7F800000, FF800000, 0) gives 7FC00000. (3F800000, BF800000, 00000000) gives 00000000.
- NUM_INPUTS=1: each sample is echoed 1 cycle later. Separately, NUM_INPUTS=3 with ADDER_N_RELU_OUT_EN defined: (C0A00000, 3F800000, 3F800000) gives 00000000; without the macro it gives C0400000.
